// File: rtl/force_bank_pkg.sv
// Shared types for the force/release register bank: command opcodes and
// the release-all sweep FSM states.
package force_bank_pkg;

    typedef enum logic [1:0] {
        OP_NOP         = 2'd0,
        OP_FORCE       = 2'd1,
        OP_RELEASE     = 2'd2,
        OP_RELEASE_ALL = 2'd3
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/force_bank_channel.sv
// One channel of the bank: underlying register, per-bit force mask/value and
// the visible-value mux. Released bits inherit the forced value into r.
module force_bank_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             force_stb,
    input  logic             release_stb,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] q,
    output logic             forced
);

    logic [WIDTH-1:0] r_reg, fm_reg, fv_reg;
    logic [WIDTH-1:0] r_next, fm_next, fv_next;
    logic [WIDTH-1:0] rel_m;

    always_comb begin
        rel_m   = release_stb ? (mask & fm_reg) : '0;
        r_next  = en ? d : r_reg;
        // The release write-back takes priority over a same-edge sample.
        r_next  = (r_next & ~rel_m) | (fv_reg & rel_m);
        fm_next = fm_reg & ~rel_m;
        fv_next = fv_reg;
        if (force_stb) begin
            fm_next = fm_next | mask;
            fv_next = (fv_reg & ~mask) | (value & mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg  <= '0;
            fm_reg <= '0;
            fv_reg <= '0;
        end else begin
            r_reg  <= r_next;
            fm_reg <= fm_next;
            fv_reg <= fv_next;
        end
    end

    assign q      = (fv_reg & fm_reg) | (r_reg & ~fm_reg);
    assign forced = |fm_reg;

endmodule

// File: rtl/force_release_bank.sv
// Bank of CHANNELS force/release registers with a command port, sticky
// out-of-range error and a sequenced one-channel-per-cycle release-all sweep.
module force_release_bank
    import force_bank_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] d_in,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [CHW-1:0]            cmd_chan,
    input  logic [WIDTH-1:0]          cmd_mask,
    input  logic [WIDTH-1:0]          cmd_value,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       forced,
    output logic                      busy,
    output logic                      cmd_err
);

    state_e         state_reg, state_next;
    logic [CHW-1:0] k_reg, k_next;
    logic           err_reg, err_next;

    cmd_op_e        op;
    logic           accept;
    logic           in_range;
    logic           sweeping;
    logic           last_k;
    logic [WIDTH-1:0] chan_mask;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = (state_reg == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign in_range  = int'(cmd_chan) < CHANNELS;
    assign sweeping  = (state_reg == ST_SWEEP);
    assign last_k    = int'(k_reg) == CHANNELS - 1;
    // No command is accepted during a sweep, so one shared mask bus suffices.
    assign chan_mask = sweeping ? '1 : cmd_mask;
    assign busy      = sweeping;
    assign cmd_err   = err_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic sel;
            logic force_stb;
            logic release_stb;

            assign sel         = accept && in_range && (int'(cmd_chan) == gi);
            assign force_stb   = sel && (op == OP_FORCE);
            assign release_stb = (sel && (op == OP_RELEASE))
                               || (sweeping && (int'(k_reg) == gi));

            force_bank_channel #(.WIDTH(WIDTH)) u_chan (
                .clk         (clk),
                .rst         (rst),
                .en          (en[gi]),
                .d           (d_in[gi*WIDTH +: WIDTH]),
                .force_stb   (force_stb),
                .release_stb (release_stb),
                .mask        (chan_mask),
                .value       (cmd_value),
                .q           (q[gi*WIDTH +: WIDTH]),
                .forced      (forced[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        // RELEASE_ALL ignores cmd_chan, so it never flags an error.
        err_next   = err_reg | (accept && (op != OP_RELEASE_ALL) && !in_range);
        case (state_reg)
            ST_IDLE: begin
                if (accept && (op == OP_RELEASE_ALL)) begin
                    state_next = ST_SWEEP;
                    k_next     = '0;
                end
            end
            ST_SWEEP: begin
                if (last_k) begin
                    state_next = ST_IDLE;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                k_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            err_reg   <= err_next;
        end
    end

endmodule
